// File: rtl/rca_config_unit_pkg.sv
// Shared types and constants for the RCA config unit: id/port/register types,
// the per-RCA port map record and the config/use funct3 encodings.
package rca_config_unit_pkg;

  localparam int RCA_NUM_RCAS        = 4;
  localparam int RCA_NUM_READ_PORTS  = 5;
  localparam int RCA_NUM_WRITE_PORTS = 5;
  localparam int RCA_ID_W            = $clog2(RCA_NUM_RCAS);

  localparam logic [2:0] RCA_FUNCT3_CFG = 3'b001;
  localparam logic [2:0] RCA_FUNCT3_USE = 3'b010;

  typedef logic [RCA_ID_W-1:0] rca_id_t;
  typedef logic [2:0]          port_idx_t;
  typedef logic [4:0]          rf_addr_t;

  // Port p occupies src_addr[p] / dst_addr[p]; the flat disp_* buses reuse this packing.
  typedef struct packed {
    rf_addr_t [RCA_NUM_READ_PORTS-1:0]  src_addr;
    logic     [RCA_NUM_READ_PORTS-1:0]  src_en;
    rf_addr_t [RCA_NUM_WRITE_PORTS-1:0] dst_addr;
    logic     [RCA_NUM_WRITE_PORTS-1:0] dst_en;
  } rca_port_map_t;

  function automatic logic port_in_range(input logic is_dst, input port_idx_t port);
    if (is_dst) return int'(port) < RCA_NUM_WRITE_PORTS;
    else        return int'(port) < RCA_NUM_READ_PORTS;
  endfunction

endpackage

// File: rtl/rca_config_unit_port_map_bank.sv
// NUM_RCAS-entry store of per-RCA port maps: one single-field write port and
// one asynchronous whole-entry read port.
module rca_config_unit_port_map_bank
  import rca_config_unit_pkg::*;
#(
  parameter int NUM_RCAS = RCA_NUM_RCAS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  rca_id_t       wr_rca,
  input  logic          wr_is_dst,
  input  port_idx_t     wr_port,
  input  rf_addr_t      wr_addr,
  input  rca_id_t       rd_rca,
  output rca_port_map_t rd_map
);

  rca_port_map_t map_q [NUM_RCAS];

  // NOTE: this array is reset on purpose -- the enable bits must read 0
  // immediately after rst_n falls, so it cannot map onto a plain RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RCAS; i++) map_q[i] <= '0;
    end else if (wr_en) begin
      if (wr_is_dst) begin
        map_q[wr_rca].dst_addr[wr_port] <= wr_addr;
        map_q[wr_rca].dst_en[wr_port]   <= 1'b1;
      end else begin
        map_q[wr_rca].src_addr[wr_port] <= wr_addr;
        map_q[wr_rca].src_en[wr_port]   <= 1'b1;
      end
    end
  end

  assign rd_map = map_q[rd_rca];

endmodule

// File: rtl/rca_config_unit.sv
// RCA issue front end: config writes the port map, use emits a held dispatch packet.
// Optional RCA_CFG_PORT_CHECK_EN: out-of-range config ports raise a one-cycle cfg_err.
module rca_config_unit
  import rca_config_unit_pkg::*;
#(
  // Port-map record widths come from the package; keep these at their defaults.
  parameter int NUM_RCAS        = RCA_NUM_RCAS,
  parameter int NUM_READ_PORTS  = RCA_NUM_READ_PORTS,
  parameter int NUM_WRITE_PORTS = RCA_NUM_WRITE_PORTS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         issue_is_cfg,
  input  logic [$clog2(NUM_RCAS)-1:0]  issue_rca,
  input  logic [2:0]                   issue_port,
  input  logic                         issue_is_dst,
  input  logic [4:0]                   issue_reg,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [$clog2(NUM_RCAS)-1:0]  disp_rca,
  output logic [NUM_READ_PORTS*5-1:0]  disp_src_addr,
  output logic [NUM_READ_PORTS-1:0]    disp_src_en,
  output logic [NUM_WRITE_PORTS*5-1:0] disp_dst_addr,
  output logic [NUM_WRITE_PORTS-1:0]   disp_dst_en,
  input  logic                         done_valid,
  input  logic [$clog2(NUM_RCAS)-1:0]  done_rca,
  output logic [NUM_RCAS-1:0]          rca_busy,
  output logic                         cfg_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [NUM_RCAS-1:0] busy_q, busy_d;
  logic                disp_valid_q;
  rca_id_t             pkt_rca_q;
  rca_port_map_t       pkt_map_q;
  rca_port_map_t       rd_map;

  logic accept;
  logic cfg_fire;
  logic use_fire;
  logic port_ok;

  // Ready depends on the target RCA, so a stalled instruction can be replaced by one that proceeds.
  assign issue_ready = (state_q == ST_IDLE) && !busy_q[issue_rca];
  assign accept      = issue_valid && issue_ready;
  assign cfg_fire    = accept && issue_is_cfg;
  assign use_fire    = accept && !issue_is_cfg;
  assign port_ok     = port_in_range(issue_is_dst, issue_port);

  rca_config_unit_port_map_bank #(
    .NUM_RCAS (NUM_RCAS)
  ) u_map_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (cfg_fire && port_ok),
    .wr_rca    (issue_rca),
    .wr_is_dst (issue_is_dst),
    .wr_port   (issue_port),
    .wr_addr   (issue_reg),
    .rd_rca    (issue_rca),
    .rd_map    (rd_map)
  );

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    busy_d  = busy_q;
    // Clearing a non-busy flag is a no-op, which is how a stray done is ignored.
    if (done_valid) busy_d[done_rca] = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (use_fire) begin
          state_d           = ST_HOLD;
          busy_d[issue_rca] = 1'b1;
        end
      end
      ST_HOLD: begin
        if (disp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= '0;
      disp_valid_q <= 1'b0;
      pkt_rca_q    <= '0;
      pkt_map_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (use_fire) begin
        disp_valid_q <= 1'b1;
        pkt_rca_q    <= issue_rca;
        pkt_map_q    <= rd_map;
      end else if (disp_valid_q && disp_ready) begin
        disp_valid_q <= 1'b0;
      end
    end
  end

  assign disp_valid    = disp_valid_q;
  assign disp_rca      = pkt_rca_q;
  assign disp_src_addr = pkt_map_q.src_addr;
  assign disp_src_en   = pkt_map_q.src_en;
  assign disp_dst_addr = pkt_map_q.dst_addr;
  assign disp_dst_en   = pkt_map_q.dst_en;
  assign rca_busy      = busy_q;

`ifdef RCA_CFG_PORT_CHECK_EN
  logic cfg_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_fire && !port_ok;
  end

  assign cfg_err = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_rca_config_unit.sv
// Scoreboarded bench for rca_config_unit: uses push expected packets, a
// negedge monitor pops them on each dispatch handshake.
module tb_rca_config_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready, issue_is_cfg, issue_is_dst;
  logic [1:0]  issue_rca;
  logic [2:0]  issue_port;
  logic [4:0]  issue_reg;
  logic        disp_valid, disp_ready;
  logic [1:0]  disp_rca;
  logic [24:0] disp_src_addr, disp_dst_addr;
  logic [4:0]  disp_src_en, disp_dst_en;
  logic        done_valid;
  logic [1:0]  done_rca;
  logic [3:0]  rca_busy;
  logic        cfg_err;

  typedef struct {
    logic [1:0]  rca;
    logic [24:0] src_addr;
    logic [4:0]  src_en;
    logic [24:0] dst_addr;
    logic [4:0]  dst_en;
  } pkt_t;

  pkt_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [4:0] m_src_addr [4][5];
  logic [4:0] m_dst_addr [4][5];
  logic [4:0] m_src_en   [4];
  logic [4:0] m_dst_en   [4];

`ifdef RCA_CFG_PORT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  rca_config_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_is_cfg  (issue_is_cfg),
    .issue_rca     (issue_rca),
    .issue_port    (issue_port),
    .issue_is_dst  (issue_is_dst),
    .issue_reg     (issue_reg),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_rca      (disp_rca),
    .disp_src_addr (disp_src_addr),
    .disp_src_en   (disp_src_en),
    .disp_dst_addr (disp_dst_addr),
    .disp_dst_en   (disp_dst_en),
    .done_valid    (done_valid),
    .done_rca      (done_rca),
    .rca_busy      (rca_busy),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_pkt(input string name, input pkt_t e);
    check({name, ".valid"},    32'(disp_valid),    32'd1);
    check({name, ".rca"},      32'(disp_rca),      32'(e.rca));
    check({name, ".src_addr"}, 32'(disp_src_addr), 32'(e.src_addr));
    check({name, ".src_en"},   32'(disp_src_en),   32'(e.src_en));
    check({name, ".dst_addr"}, 32'(disp_dst_addr), 32'(e.dst_addr));
    check({name, ".dst_en"},   32'(disp_dst_en),   32'(e.dst_en));
  endtask

  // Monitor: a handshake completes at the next rising edge, so each packet is popped once.
  always @(negedge clk) begin
    if (rst_n && disp_valid && disp_ready) begin
      if (sb.size() == 0) check("unexpected_packet", 32'd1, 32'd0);
      else                check_pkt("disp_pkt", sb.pop_front());
    end
  end

  function automatic pkt_t build_exp(input logic [1:0] r);
    pkt_t p;
    p.rca = r;
    p.src_addr = '0;
    p.dst_addr = '0;
    for (int i = 0; i < 5; i++) begin
      p.src_addr[5*i +: 5] = m_src_addr[int'(r)][i];
      p.dst_addr[5*i +: 5] = m_dst_addr[int'(r)][i];
    end
    p.src_en = m_src_en[int'(r)];
    p.dst_en = m_dst_en[int'(r)];
    return p;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 4; r++) begin
      m_src_en[r] = '0;
      m_dst_en[r] = '0;
      for (int p = 0; p < 5; p++) begin
        m_src_addr[r][p] = '0;
        m_dst_addr[r][p] = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic cfg, input logic [1:0] rca, input logic [2:0] port,
                      input logic dst, input logic [4:0] rg, output int stalls);
    stalls       = 0;
    issue_valid  = 1'b1;
    issue_is_cfg = cfg;
    issue_rca    = rca;
    issue_port   = port;
    issue_is_dst = dst;
    issue_reg    = rg;
    #1;
    while (!issue_ready && stalls < 20) begin
      tick();
      stalls++;
    end
    if (!issue_ready) check("issue_ready_timeout", 32'(issue_ready), 32'd1);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    if (cfg && port < 3'd5) begin
      if (dst) begin
        m_dst_addr[int'(rca)][int'(port)] = rg;
        m_dst_en[int'(rca)][port] = 1'b1;
      end else begin
        m_src_addr[int'(rca)][int'(port)] = rg;
        m_src_en[int'(rca)][port] = 1'b1;
      end
    end
  endtask

  task automatic send_use(input logic [1:0] rca, input pkt_t e);
    int st;
    sb.push_back(e);
    send(1'b0, rca, 3'd0, 1'b0, 5'd0, st);
    check("use_latency", 32'(disp_valid), 32'd1);
  endtask

  task automatic done(input logic [1:0] r);
    done_valid = 1'b1;
    done_rca   = r;
    tick();
    done_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t e;
    int   st;
    int   c0;
    int   tot;

    clear_model();
    rst_n = 1'b0; issue_valid = 0; issue_is_cfg = 0; issue_rca = 0; issue_port = 0;
    issue_is_dst = 0; issue_reg = 0; disp_ready = 0; done_valid = 0; done_rca = 0;
    #12;
    check("rst.disp_valid", 32'(disp_valid), 32'd0);
    check("rst.busy",       32'(rca_busy),   32'd0);
    check("rst.cfg_err",    32'(cfg_err),    32'd0);
    check("rst.src_en",     32'(disp_src_en), 32'd0);
    check("rst.ready",      32'(issue_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: two configs on rca0, then a use with a hand-computed packet
    send(1'b1, 2'd0, 3'd2, 1'b0, 5'd7, st);
    send(1'b1, 2'd0, 3'd0, 1'b1, 5'd9, st);
    disp_ready = 1'b1;
    e = '{rca: 2'd0, src_addr: 25'd7 << 10, src_en: 5'b00100, dst_addr: 25'd9, dst_en: 5'b00001};
    send_use(2'd0, e);
    check("t1.busy", 32'(rca_busy), 32'b0001);
    tick();
    check("t1.idle_after_ack", 32'(disp_valid), 32'd0);
    done(2'd0);
    check("t1.busy_cleared", 32'(rca_busy), 32'd0);

    // 2: use rca1 with downstream stalled for 3 cycles
    disp_ready = 1'b0;
    e = build_exp(2'd1);
    send_use(2'd1, e);
    for (int i = 0; i < 3; i++) begin
      check("t2.ready_in_hold", 32'(issue_ready), 32'd0);
      check_pkt("t2.stable", e);
      tick();
    end
    disp_ready = 1'b1;
    tick();
    check("t2.valid_dropped", 32'(disp_valid), 32'd0);
    issue_rca = 2'd0;
    #1;
    check("t2.ready_idle", 32'(issue_ready), 32'd1);
    done(2'd1);

    // 3: config to a busy rca2 stalls until its done
    send_use(2'd2, build_exp(2'd2));
    issue_valid = 1'b1; issue_is_cfg = 1'b1; issue_rca = 2'd2;
    issue_port = 3'd1; issue_is_dst = 1'b0; issue_reg = 5'd12;
    tick();
    check("t3.stall_a", 32'(issue_ready), 32'd0);
    tick();
    check("t3.stall_b", 32'(issue_ready), 32'd0);
    done_valid = 1'b1; done_rca = 2'd2;
    #1;
    check("t3.stall_on_done", 32'(issue_ready), 32'd0);
    tick();
    done_valid = 1'b0;
    check("t3.ready_after_done", 32'(issue_ready), 32'd1);
    send(1'b1, 2'd2, 3'd1, 1'b0, 5'd12, st);
    check("t3.cfg_no_stall", 32'(st), 32'd0);
    send_use(2'd2, build_exp(2'd2));
    done(2'd2);

    // 4: out-of-range config ports on rca3 (src 6, dst at the limit 5)
    send(1'b1, 2'd3, 3'd6, 1'b0, 5'd15, st);
    check("t4.cfg_err_src", 32'(cfg_err), 32'(EXP_ERR));
    tick();
    check("t4.cfg_err_pulse", 32'(cfg_err), 32'd0);
    send(1'b1, 2'd3, 3'd5, 1'b1, 5'd16, st);
    check("t4.cfg_err_dst", 32'(cfg_err), 32'(EXP_ERR));

    // 6: four back-to-back configs on rca3, including the top valid port
    c0 = cyc; tot = 0;
    send(1'b1, 2'd3, 3'd4, 1'b0, 5'd21, st); tot += st;
    send(1'b1, 2'd3, 3'd4, 1'b1, 5'd22, st); tot += st;
    send(1'b1, 2'd3, 3'd1, 1'b0, 5'd3,  st); tot += st;
    send(1'b1, 2'd3, 3'd3, 1'b1, 5'd30, st); tot += st;
    check("t6.stalls", 32'(tot), 32'd0);
    check("t6.cycles", 32'(cyc - c0), 32'd4);
    send_use(2'd3, build_exp(2'd3));
    done(2'd3);

    // 5: asynchronous reset while holding a packet for rca0
    disp_ready = 1'b0;
    send_use(2'd0, build_exp(2'd0));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.disp_valid", 32'(disp_valid),  32'd0);
    check("t5.busy",       32'(rca_busy),    32'd0);
    check("t5.src_en",     32'(disp_src_en), 32'd0);
    check("t5.dst_en",     32'(disp_dst_en), 32'd0);
    sb.delete();
    clear_model();
    #2;
    rst_n = 1'b1;
    tick();
    disp_ready = 1'b1;
    send_use(2'd0, build_exp(2'd0));
    tick();
    done(2'd0);

    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
